// File: rtl/stream_mux_n_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//
// Shared definitions for the stream_mux_n operand selector.
//   mux_mode_t  : selection mode (fixed software-chosen channel or round-robin)
//   rr_ptr_rst(): reset value of the round-robin pointer for a given channel
//                 count. The pointer rests on the last channel, so the first
//                 search after reset starts at channel 0.
// ---------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  function automatic int rr_ptr_rst(input int n_in);
    return n_in - 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational find-first-from-pointer arbiter. The search starts at
// (ptr + 1) mod N_IN and walks upward with wrap-around, so the channel named
// by ptr is considered last.
//
// Ports:
//   req       in   N_IN   request vector (one bit per channel)
//   ptr       in   SEL_W  index of the most recently granted channel
//   gnt_valid out  1      at least one request is set
//   gnt_idx   out  SEL_W  index of the granted channel (0 when gnt_valid = 0)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_s;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_s     = '0;
    // Offsets 1..N_IN visit every channel once, ending on ptr itself.
    for (int k = 1; k <= N_IN; k++) begin
      idx   = (int'(ptr) + k) % N_IN;
      idx_s = SEL_W'(idx);
      if (!gnt_valid && req[idx_s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_s;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// ---------------------------------------------------------------------------
// stream_mux_n
//
// N-input, WIDTH-bit stream multiplexer with valid/ready handshakes on every
// port and one registered output stage. A channel is chosen either by a fixed
// software select or by round-robin arbitration among valid channels; the
// chosen beat is registered and held until the consumer accepts it.
//
// Ports:
//   clk        in   1            clock, rising edge
//   rst        in   1            synchronous, active-high reset
//   mode       in   1            0 = MODE_FIXED, 1 = MODE_RR
//   sel        in   SEL_W        channel index used in MODE_FIXED
//   in_data    in   N_IN x WIDTH packed channel data
//   in_valid   in   N_IN         per-channel valid
//   in_ready   out  N_IN         per-channel ready (combinational, one-hot/zero)
//   out_data   out  WIDTH        registered selected data
//   out_src    out  SEL_W        registered index of the supplying channel
//   out_valid  out  1            a beat is held in the output stage
//   out_ready  in   1            consumer accepts the beat
// ---------------------------------------------------------------------------
module stream_mux_n
  import mux_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  input  logic [N_IN-1:0][WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]            in_valid,
  output logic [N_IN-1:0]            in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [SEL_W-1:0]           out_src,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam logic [SEL_W-1:0] RR_PTR_RST = SEL_W'(rr_ptr_rst(N_IN));

  mux_mode_t        cur_mode;
  logic [SEL_W-1:0] ptr_q;

  logic             rr_gnt_valid;
  logic [SEL_W-1:0] rr_gnt_idx;
  logic             sel_in_range;
  logic             fix_gnt_valid;

  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             load_en;
  logic             xfer;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] src_p1;

  assign cur_mode = mux_mode_t'(mode);

  rr_arbiter #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  // When N_IN fills the select width every sel value is a real channel;
  // otherwise indices at or above N_IN never grant.
  generate
    if ((1 << SEL_W) == N_IN) begin : g_sel_full
      assign sel_in_range = 1'b1;
    end else begin : g_sel_partial
      assign sel_in_range = (sel < SEL_W'(N_IN));
    end
  endgenerate

  assign fix_gnt_valid = sel_in_range && in_valid[sel];

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (cur_mode == MODE_RR) begin
      gnt_valid = rr_gnt_valid;
      gnt_idx   = rr_gnt_idx;
    end else begin
      gnt_valid = fix_gnt_valid;
      gnt_idx   = sel;
    end
  end

  // The output stage accepts a new beat when empty or draining this cycle,
  // so a continuous stream flows with no bubble while out_ready stays high.
  assign load_en = !vld_p1 || out_ready;
  assign xfer    = load_en && gnt_valid && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output register stage (p1). A held beat is only replaced when the
  // consumer takes it in the same cycle; reset discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      ptr_q   <= RR_PTR_RST;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data[gnt_idx];
      src_p1  <= gnt_idx;
      if (cur_mode == MODE_RR) begin
        ptr_q <= gnt_idx;
      end
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_src   = src_p1;

endmodule

// File: tb/tb_stream_mux_n.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_n
//
// Scoreboard bench for stream_mux_n (N_IN = 4, WIDTH = 8). The driver issues
// stimulus each cycle and pushes the beat a reference model says will be
// loaded; an independent monitor compares and pops whenever the DUT presents
// a beat. Directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_stream_mux_n;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_src;
  logic              out_valid;
  logic              out_ready;

  always #5 clk = ~clk;

  stream_mux_n #(
    .N_IN  (N),
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
  } beat_t;

  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model state: whether a beat is held, and the last RR winner.
  bit    m_vld;
  int    m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit vbit(input logic [N-1:0] v, input int i);
    logic [N-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  // Winner is the valid channel with the smallest cyclic distance after the
  // pointer (RR), or sel itself when valid (fixed). -1 means no grant.
  function automatic int model_grant(input logic [N-1:0] v, input bit m,
                                     input int s, input int p);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    if (!m) begin
      for (int i = 0; i < N; i++)
        if (i == s && vbit(v, i)) best = i;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vbit(v, i)) begin
          d = (i - p - 1 + 2 * N) % N;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
    end
    return best;
  endfunction

  // One clock cycle: called just after a falling edge with inputs already set.
  task automatic tick();
    int           g;
    bit           ld;
    logic [N-1:0] exp_rdy;
    logic [N*W-1:0] flat;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    ld      = !m_vld || out_ready;
    g       = model_grant(in_valid, mode, int'(sel), m_ptr);
    exp_rdy = '0;
    if (rst) begin
      sb.delete();
      m_vld = 1'b0;
      m_ptr = N - 1;
    end else if (ld && g >= 0) begin
      exp_rdy = N'(1) << g;
      flat    = in_data;
      flat    = flat >> (g * W);
      sb.push_back(beat_t'{d: flat[W-1:0], s: SW'(g)});
      m_vld = 1'b1;
      if (mode) m_ptr = g;
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
    chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    @(negedge clk);
  endtask

  // Monitor: compares every presented beat against the scoreboard head and
  // pops it when the consumer accepts.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got beat %0h/%0h expected none at %0t",
                   out_data, out_src, $time);
        end else begin
          chk("sb_data", {24'd0, out_data}, {24'd0, sb[0].d});
          chk("sb_src", {30'd0, out_src}, {30'd0, sb[0].s});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  int wrap_exp[3] = '{0, 3, 0};

  initial begin
    rst       = 1'b1;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    m_vld     = 1'b0;
    m_ptr     = N - 1;
    @(negedge clk);

    // Reset with every channel requesting
    #1;
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_src", {30'd0, out_src}, 32'd0);

    // Round-robin stream, all channels valid
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_src", {30'd0, out_src}, k % 4);
      chk("rr_data", {24'd0, out_data}, 32'h10 + (k % 4));
      chk("rr_valid", {31'd0, out_valid}, 32'd1);
    end

    // Fixed select
    mode       = 1'b0;
    sel        = 2'd2;
    in_data[2] = 8'hA5;
    in_valid   = 4'b0100;
    #1;
    chk("fix_ready", {28'd0, in_ready}, 32'b0100);
    tick();
    chk("fix_data", {24'd0, out_data}, 32'hA5);
    chk("fix_src", {30'd0, out_src}, 32'd2);
    chk("fix_valid", {31'd0, out_valid}, 32'd1);
    sel = 2'd1;
    #1;
    chk("fix_nogrant_ready", {28'd0, in_ready}, 32'd0);
    tick();
    chk("fix_nogrant_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure
    mode       = 1'b1;
    in_valid   = 4'b0010;
    in_data[1] = 8'h3C;
    tick();
    chk("bp_load_data", {24'd0, out_data}, 32'h3C);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", {28'd0, in_ready}, 32'd0);
      tick();
      chk("bp_data", {24'd0, out_data}, 32'h3C);
      chk("bp_src", {30'd0, out_src}, 32'd1);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_src", {30'd0, out_src}, 32'd2);

    // Wrap-around with sparse requests
    in_valid = 4'b1000;
    tick();
    chk("wrap_setup_src", {30'd0, out_src}, 32'd3);
    in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wrap_src", {30'd0, out_src}, wrap_exp[k]);
    end

    // Reset while a beat is held
    mode       = 1'b0;
    sel        = 2'd0;
    in_valid   = 4'b0001;
    in_data[0] = 8'h77;
    tick();
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    tick();
    chk("hold_data", {24'd0, out_data}, 32'h77);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'd0);
    chk("midrst_src", {30'd0, out_src}, 32'd0);
    rst       = 1'b0;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    chk("midrst_first_rr", {30'd0, out_src}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(63) == 0);
      mode      = 1'($urandom_range(1));
      sel       = SW'($urandom_range(N - 1));
      in_valid  = N'($urandom());
      in_data   = $urandom();
      out_ready = ($urandom_range(3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-input, WIDTH-bit multiplexer with a valid/ready handshake on every port and one registered output stage. It is the sequential successor of the ALU's 4:1 bit mux. It selects either a fixed, software-chosen channel or arbitrates round-robin among active channels, then holds the selected beat until the consumer takes it. It sits between operand sources (register file ports, immediate path, forwarding paths) and an ALU operand input that can stall.

## Interface
Parameters:
- N_IN, 4: number of input channels, 2..16.
- WIDTH, 8: data width per channel, ≥1.
- SEL_W, $clog2(N_IN): width of sel and out_src (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode  in  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR).
- sel  in  SEL_W  channel index used in MODE_FIXED.
- in_data  in  N_IN×WIDTH  packed array of channel data.
- in_valid  in  N_IN  per-channel valid.
- in_ready  out  N_IN  per-channel ready; combinational; at most one bit set.
- out_data  out  WIDTH  registered selected data.
- out_src  out  SEL_W  registered index of the channel that supplied out_data.
- out_valid  out  1  registered; a beat is held in the output stage.
- out_ready  in  1  consumer accepts the beat.

## Operation
- load_en = !out_valid || out_ready. The output stage can take a new beat when it is empty or draining in the same cycle.
- Grant is computed combinationally each cycle:
  - MODE_FIXED: grant = sel if in_valid[sel]; otherwise no grant. If sel ≥ N_IN, there is no grant.
  - MODE_RR: search from (ptr+1) mod N_IN upward with wrap-around. Grant the first index with in_valid set. No valid channels means no grant.
- in_ready[i] = load_en && grant valid && grant == i && !rst.
- Transfer from channel i occurs when in_valid[i] && in_ready[i]. On the next edge: out_data ← in_data[i], out_src ← i, out_valid ← 1.
  - In MODE_RR, ptr ← i, so the granted channel gets lowest priority next time.
  - In MODE_FIXED, ptr is unchanged.
- If out_valid && out_ready and there is no transfer, out_valid ← 0. out_data and out_src keep their last values.
- A held beat (out_valid && !out_ready) is never overwritten. out_data and out_src are stable until accepted.
- mode and sel are sampled only in cycles where load_en = 1. Changing them while a beat is held has no effect on that beat.
- Input handshake assumption: a channel may not drop in_valid before it is granted. in_valid is not otherwise checked.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle while out_ready = 1.
- Reset: out_valid = 0, out_data = 0, out_src = 0, ptr = N_IN−1 (first RR priority is channel 0). in_ready is all zero while rst = 1.
- Reset mid-operation: a held beat is discarded. No input transfer occurs in the reset cycle.
- Simultaneous accept and load in the same cycle: the new beat replaces the old one with out_valid staying 1, giving a back-to-back stream with no bubble.
- RR wrap-around: ptr = N_IN−1 searches from 0. ptr = k searches k+1 .. N_IN−1, 0 .. k.
- Single requester in MODE_RR is granted every cycle; ptr stays at its index.

## Structure
- Package mux_pkg:
  - typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_t.
  - Reset constant RR_PTR_RST = N_IN−1, expressed as a function of N_IN.
- Sub-module rr_arbiter (N_IN): inputs req[N_IN] and ptr; outputs gnt_valid and gnt_idx. Purely combinational find-first-from-pointer.
- stream_mux_n contains:
  - the mode/sel grant mux;
  - load_en logic;
  - the ptr register;
  - the output register stage.

## Test plan
- Reset: assert rst with all in_valid = 1111. Required: in_ready = 0000, out_valid = 0, out_data = 0, out_src = 0. Release rst in MODE_RR; first grant is channel 0.
- MODE_FIXED, sel = 2, in_data[2] = 8'hA5, in_valid = 0100, out_ready = 1. Required: in_ready = 0100. Next cycle: out_data = A5, out_src = 2, out_valid = 1. With sel = 1 and in_valid = 0100: no grant, out_valid falls to 0.
- MODE_RR, in_valid = 1111 constant, out_ready = 1, in_data[i] = 8'h10+i. Required: out_src sequence 0,1,2,3,0,1 with out_data 10,11,12,13,10,11, one beat per cycle and no bubbles.
- Backpressure: load channel 1 (data 8'h3C), then hold out_ready = 0 for 3 cycles with in_valid = 1111. Required: in_ready = 0000, out_data = 3C and out_src = 1 stable. Raise out_ready: next beat is from channel 2 the following cycle.
- RR wrap with sparse requests: ptr at 3, in_valid = 1001. Required: channel 0 granted, then channel 3, then channel 0.
- Reset mid-stream: out_valid = 1 holding 8'h77 and out_ready = 0, assert rst for one cycle. Required: out_valid = 0 and out_data = 0 after the edge. The held beat is never accepted, and ptr restarts at N_IN−1.
